// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - Wait-stated data memory with byte/half/word access and a single-request handshake.
// Optional DMEM_ALIGN_CHECK_EN adds the Err port and turns misaligned accesses into errors.
module dmem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Req,
    input  logic                  WE,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Valid,
    output logic [DATA_WIDTH-1:0] ReadData
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic                  Err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-2:0] DEPTH_LIM = (ADDR_WIDTH-1)'(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT                 state;
    logic [3:0]            waitCnt;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic                  weQ;
    logic [1:0]            sizeQ;
    logic                  unsQ;
    logic [DATA_WIDTH-1:0] wdataQ;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-3:0] wordIdx;
    logic [IDX_W-1:0]      memIdx;
    logic [1:0]            lane;
    logic                  inRange;
    logic                  accessErr;
    logic                  commit;
    logic [DATA_WIDTH-1:0] curWord;
    logic [DATA_WIDTH-1:0] storeWord;
    logic [DATA_WIDTH-1:0] loadResult;
    logic [7:0]            byteVal;
    logic [15:0]           halfVal;

    assign wordIdx = addrQ[ADDR_WIDTH-1:2];
    assign memIdx  = wordIdx[IDX_W-1:0];
    assign lane    = addrQ[1:0];
    assign inRange = {1'b0, wordIdx} < DEPTH_LIM;
    assign commit  = (state == WAIT) && (waitCnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign accessErr = !inRange || ((sizeQ == 2'b01) && lane[0]) || (sizeQ[1] && (lane != 2'b00));
`else
    assign accessErr = !inRange;
`endif

    // Low address bits below the access size are simply not used, which forces alignment.
    always_comb begin
        curWord    = mem[memIdx];
        byteVal    = curWord[{lane, 3'b000} +: 8];
        halfVal    = curWord[{lane[1], 4'b0000} +: 16];
        storeWord  = curWord;
        loadResult = '0;
        case (sizeQ)
            2'b00: begin
                storeWord[{lane, 3'b000} +: 8] = wdataQ[7:0];
                loadResult = {{24{~unsQ & byteVal[7]}}, byteVal};
            end
            2'b01: begin
                storeWord[{lane[1], 4'b0000} +: 16] = wdataQ[15:0];
                loadResult = {{16{~unsQ & halfVal[15]}}, halfVal};
            end
            default: begin
                storeWord  = wdataQ;
                loadResult = curWord;
            end
        endcase
        if (accessErr) loadResult = '0;
    end

    // Gated by Rst_n so a reset landing on the commit edge aborts the store.
    always_ff @(posedge Clk) begin
        if (Rst_n && commit && weQ && !accessErr) mem[memIdx] <= storeWord;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= IDLE;
            waitCnt  <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            Valid    <= 1'b0;
            ReadData <= '0;
            addrQ    <= '0;
            weQ      <= 1'b0;
            sizeQ    <= 2'b00;
            unsQ     <= 1'b0;
            wdataQ   <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            Err      <= 1'b0;
`endif
        end else begin
            Valid <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            Err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (Req && Ready) begin
                        addrQ   <= Address;
                        weQ     <= WE;
                        sizeQ   <= Size;
                        unsQ    <= Unsigned;
                        wdataQ  <= WriteData;
                        waitCnt <= WAIT_INIT;
                        state   <= WAIT;
                        Ready   <= 1'b0;
                        Busy    <= 1'b1;
                    end else begin
                        Ready   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        state <= RESP;
                        Valid <= 1'b1;
                        if (!weQ) ReadData <= loadResult;
`ifdef DMEM_ALIGN_CHECK_EN
                        Err   <= accessErr;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - Scoreboard bench for dmem_ctrl (ADDR_WIDTH=11, DEPTH=256, WAIT_STATES=1).
module tb_dmem_ctrl;

    localparam int AW    = 11;
    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Req = 1'b0;
    logic          WE = 1'b0;
    logic [1:0]    Size = 2'b10;
    logic          Unsigned = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [31:0]   WriteData = '0;
    logic          Ready;
    logic          Busy;
    logic          Valid;
    logic [31:0]   ReadData;
`ifdef DMEM_ALIGN_CHECK_EN
    logic          Err;
`endif

    dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .WE(WE), .Size(Size), .Unsigned(Unsigned),
        .Address(Address), .WriteData(WriteData), .Ready(Ready), .Busy(Busy),
        .Valid(Valid), .ReadData(ReadData)
`ifdef DMEM_ALIGN_CHECK_EN
        , .Err(Err)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          nRun = 0;
    int          nFail = 0;
    int          acceptCyc = 0;
    logic [7:0]  refMem [4*DEPTH];
    logic [31:0] modelRd = '0;
    logic [31:0] rdQ [$];
    logic        errQ [$];

    // Byte-addressed reference: expected ReadData after the access, plus whether it errors.
    function automatic logic [31:0] modelAccess(input logic we, input logic [1:0] sz, input logic uns,
                                                input logic [AW-1:0] addr, input logic [31:0] wd,
                                                output logic err);
        int n, base;
        logic [31:0] v;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(addr) - (int'(addr) % n);
        err  = (int'(addr) >= 4 * DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (base != int'(addr)) err = 1'b1;
`endif
        if (we) begin
            if (!err) for (int i = 0; i < n; i++) refMem[base + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            if (!err) begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[base + i];
                if (!uns) for (int b = 8 * n; b < 32; b++) v[b] = v[8*n - 1];
            end
            modelRd = v;
        end
        return modelRd;
    endfunction

    function automatic void pushExpected(input logic we, input logic [1:0] sz, input logic uns,
                                         input logic [AW-1:0] addr, input logic [31:0] wd);
        logic e;
        logic [31:0] r;
        r = modelAccess(we, sz, uns, addr, wd, e);
        rdQ.push_back(r);
        errQ.push_back(e);
    endfunction

    // Called at a negedge; returns at the negedge just before the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd, input bit track);
        int t;
        t = 0;
        Req = 1'b1; WE = we; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
        while (Ready !== 1'b1 && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (Ready !== 1'b1) begin
            nRun++; nFail++;
            $display("FAIL accept_timeout: Ready=%b after %0d cycles, required 1", Ready, t);
        end else if (track) begin
            pushExpected(we, sz, uns, addr, wd);
        end
        acceptCyc = cyc + 1;
    endtask

    task automatic waitDone(input string name);
        int cnt;
        logic [31:0] expRd;
        logic expErr;
        cnt = 0;
        do begin
            @(negedge Clk);
            cnt++;
            if (cnt == 1) begin
                nRun++;
                if (Busy !== 1'b1 || Ready !== 1'b0) begin
                    nFail++;
                    $display("FAIL %s_busy: Busy=%b Ready=%b, required 1 0", name, Busy, Ready);
                end
                Req = 1'b0; WE = ~WE; Size = ~Size; Unsigned = ~Unsigned;
                Address = ~Address; WriteData = ~WriteData;
            end
        end while (Valid !== 1'b1 && cnt < 20);
        nRun++;
        if (Valid !== 1'b1 || cnt != WS + 2) begin
            nFail++;
            $display("FAIL %s_latency: Valid=%b at cycle %0d, required 1 at cycle %0d", name, Valid, cnt, WS + 2);
        end
        if (rdQ.size() == 0) begin
            nRun++; nFail++;
            $display("FAIL %s_queue: scoreboard empty, required one entry", name);
        end else begin
            expRd  = rdQ.pop_front();
            expErr = errQ.pop_front();
            nRun++;
            if (ReadData !== expRd) begin
                nFail++;
                $display("FAIL %s_data: ReadData=%h, required %h", name, ReadData, expRd);
            end
`ifdef DMEM_ALIGN_CHECK_EN
            nRun++;
            if (Err !== expErr) begin
                nFail++;
                $display("FAIL %s_err: Err=%b, required %b", name, Err, expErr);
            end
`else
            if (expErr === 1'bx) $display("scoreboard err flag unknown");
`endif
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Req = 1'b0;
        repeat (2) @(negedge Clk);
        modelRd = '0;
        nRun++;
        if (Ready !== 1'b0 || Valid !== 1'b0 || Busy !== 1'b0) begin
            nFail++;
            $display("FAIL reset_ctrl: Ready=%b Valid=%b Busy=%b, required 0 0 0", Ready, Valid, Busy);
        end
        nRun++;
        if (ReadData !== 32'h0) begin
            nFail++;
            $display("FAIL reset_data: ReadData=%h, required 00000000", ReadData);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        nRun++;
        if (Ready !== 1'b1 || Busy !== 1'b0) begin
            nFail++;
            $display("FAIL reset_release: Ready=%b Busy=%b, required 1 0", Ready, Busy);
        end
    endtask

    task automatic test_word();
        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 1'b1);
        waitDone("word_store");
        @(negedge Clk);
        nRun++;
        if (Valid !== 1'b0 || Ready !== 1'b1 || Busy !== 1'b0) begin
            nFail++;
            $display("FAIL word_pulse: Valid=%b Ready=%b Busy=%b, required 0 1 0", Valid, Ready, Busy);
        end
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);
        waitDone("word_load");
    endtask

    task automatic test_subword();
        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);          waitDone("sub_clr0");
        issue(1'b1, 2'b10, 1'b0, 11'h014, 32'h0, 1'b1);          waitDone("sub_clr1");
        issue(1'b1, 2'b00, 1'b0, 11'h011, 32'hFFFFFF80, 1'b1);   waitDone("sub_sb");
        issue(1'b1, 2'b01, 1'b0, 11'h016, 32'hABCD1234, 1'b1);   waitDone("sub_sh");
        issue(1'b0, 2'b00, 1'b0, 11'h011, 32'h0, 1'b1);          waitDone("sub_lb");
        issue(1'b0, 2'b00, 1'b1, 11'h011, 32'h0, 1'b1);          waitDone("sub_lbu");
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);          waitDone("sub_lw0");
        issue(1'b0, 2'b11, 1'b0, 11'h014, 32'h0, 1'b1);          waitDone("sub_lw1");
        issue(1'b0, 2'b01, 1'b0, 11'h017, 32'h0, 1'b1);          waitDone("sub_lh_odd");
    endtask

    task automatic test_handshake();
        int c;
        logic [31:0] expRd;
        logic expErr;
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);
        c = 0;
        while (c < 20) begin
            @(negedge Clk);
            c++;
            if (c == WS + 2) begin
                expRd  = rdQ.pop_front();
                expErr = errQ.pop_front();
                nRun++;
                if (Valid !== 1'b1 || ReadData !== expRd) begin
                    nFail++;
                    $display("FAIL hs_first: Valid=%b ReadData=%h, required 1 %h", Valid, ReadData, expRd);
                end
`ifdef DMEM_ALIGN_CHECK_EN
                nRun++;
                if (Err !== expErr) begin
                    nFail++;
                    $display("FAIL hs_first_err: Err=%b, required %b", Err, expErr);
                end
`endif
            end else if (c < WS + 2) begin
                nRun++;
                if (Ready !== 1'b0 || Valid !== 1'b0) begin
                    nFail++;
                    $display("FAIL hs_busy: Ready=%b Valid=%b at cycle %0d, required 0 0", Ready, Valid, c);
                end
            end
            if (Ready === 1'b1) break;
            Address   = c[0] ? 11'h014 : 11'h010;
            WriteData = $urandom;
        end
        nRun++;
        if (c != WS + 3) begin
            nFail++;
            $display("FAIL hs_ready_cycle: Ready rose at cycle %0d, required %0d", c, WS + 3);
        end
        pushExpected(WE, Size, Unsigned, Address, WriteData);
        waitDone("hs_second");
    endtask

    task automatic test_back_to_back();
        int prev;
        for (int i = 0; i < 18; i++) begin
            if (i < 8)
                issue(1'b1, 2'b10, 1'b0, 11'(i * 4), $urandom, 1'b1);
            else
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      11'($urandom_range(0, 31)), $urandom, 1'b1);
            if (i > 0) begin
                nRun++;
                if (acceptCyc - prev != WS + 3) begin
                    nFail++;
                    $display("FAIL b2b_spacing: %0d cycles between accepts, required %0d", acceptCyc - prev, WS + 3);
                end
            end
            prev = acceptCyc;
            waitDone("b2b");
        end
    endtask

    task automatic test_boundary();
        bit sawValid;
        issue(1'b0, 2'b10, 1'b0, 11'h400, 32'h0, 1'b1);          waitDone("oor_load");
        issue(1'b1, 2'b10, 1'b0, 11'h404, 32'hFFFFFFFF, 1'b1);   waitDone("oor_store");
        issue(1'b0, 2'b10, 1'b0, 11'h004, 32'h0, 1'b1);          waitDone("oor_alias");
        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'hA5A55A5A, 1'b0);
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        sawValid = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (Valid === 1'b1) sawValid = 1'b1;
        end
        Rst_n = 1'b1;
        modelRd = '0;
        repeat (6) begin
            @(negedge Clk);
            if (Valid === 1'b1) sawValid = 1'b1;
        end
        nRun++;
        if (sawValid) begin
            nFail++;
            $display("FAIL abort_valid: Valid seen after aborted store, required none");
        end
        nRun++;
        if (ReadData !== 32'h0 || Busy !== 1'b0) begin
            nFail++;
            $display("FAIL abort_state: ReadData=%h Busy=%b, required 00000000 0", ReadData, Busy);
        end
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);          waitDone("abort_reload");
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_align_check();
        issue(1'b0, 2'b10, 1'b0, 11'h012, 32'h0, 1'b1);          waitDone("al_lw");
        issue(1'b1, 2'b01, 1'b0, 11'h013, 32'h0000BEEF, 1'b1);   waitDone("al_sh");
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b1);          waitDone("al_check");
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_handshake();
        test_back_to_back();
        test_boundary();
`ifdef DMEM_ALIGN_CHECK_EN
        test_align_check();
`endif
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, clocked data memory with a single-request handshake.
- Supports byte, halfword and word accesses with little-endian byte lanes and sign/zero extension on loads.
- Access latency is configurable through wait states.
- Sits between the datapath's memory stage and the pipeline-stall logic; Ready/Valid drive the stall.

Parameters:
- DATA_WIDTH, 32, word width in bits; fixed at 32 for sub-word lane logic, and other values are illegal.
- ADDR_WIDTH, 10, byte-address width.
- DEPTH, 256, number of words; must be ≤ 2^(ADDR_WIDTH-2).
- WAIT_STATES, 1, extra cycles between acceptance and commit; range 0..15.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Req  in  1  request strobe.
- WE  in  1  1 = store, 0 = load; sampled with Req.
- Size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- Address  in  ADDR_WIDTH  byte address.
- WriteData  in  32  store data, right-justified for sub-word stores.
- Ready  out  1  high only in IDLE; a request is accepted on an edge where Req && Ready.
- Busy  out  1  high in WAIT or RESP.
- Valid  out  1  one-cycle completion pulse, for loads and stores.
- ReadData  out  32  load result; holds its value until the next load completes.
- Err  out  1  present only with the macro (see Optional Feature).

Behaviour:
- Reset (Rst_n low at an edge):
  - State goes to IDLE; Ready=0 during the reset cycle and 1 from the first cycle after release.
  - Busy=0, Valid=0, ReadData=0, wait counter=0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on Req: latch Address, WE, Size, Unsigned and WriteData; load counter = WAIT_STATES.
  - WAIT: while counter != 0, decrement. At counter == 0, the edge commits the access and moves to RESP.
  - Commit: store writes the selected lanes; load captures the extended result into ReadData.
  - RESP: Valid=1 for exactly one cycle, then IDLE. Ready returns high in the cycle after RESP.
- Latency: accept at edge k, commit at edge k+WAIT_STATES+1, Valid high in the cycle following the commit edge. Back-to-back throughput is one access per WAIT_STATES+3 cycles.
- Req while Ready=0 is ignored; there is no queueing, so the master must hold Req until it sees Ready.
- Inputs changing after acceptance have no effect, because the latched copies are used.
- Word index = Address[ADDR_WIDTH-1:2]; byte lane = Address[1:0].
- Byte store: writes lane Address[1:0] with WriteData[7:0]; other lanes unchanged.
- Half store: writes lanes {A1,0},{A1,1} with WriteData[15:0].
- Word store: writes all four lanes.
- Load extraction: byte = lane value; half = lanes {A1,1}:{A1,0}; result extended to 32 bits per Unsigned.
- Misalignment (default build): low address bits below the access size are ignored; the access is forced aligned.
- Out of range (word index ≥ DEPTH): store is dropped, load returns 0; Valid still pulses.
- Stores do not modify ReadData.
- Reset mid-operation: if Rst_n is low on the commit edge or earlier, the access is aborted, no write occurs, and no Valid is issued.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: Err port exists.
  - A misaligned half (A0=1) or word (A1:A0 != 0) access, or an out-of-range access, completes normally in timing.
  - Err=1 coincident with Valid; the store is suppressed and the load returns 0.
  - Err=0 in all other cycles and during reset.
- Undefined: no Err port; misaligned accesses are forced aligned as above.

Test Plan:
- Reset then idle: Rst_n low 2 cycles → Ready=0, Valid=0, ReadData=0; Ready=1 the first cycle after release.
- Word store/load, WAIT_STATES=1: store 0xDEADBEEF at 0x010, then load 0x010 (Size=10) → each Valid exactly 3 cycles after acceptance; ReadData=0xDEADBEEF.
- Sub-word:
  - Store byte 0x80 at 0x011 and half 0x1234 at 0x016, over the word 0 at 0x010 and 0x014.
  - Load byte 0x011, Unsigned=0 → 0xFFFFFF80; Unsigned=1 → 0x00000080.
  - Load word 0x010 → 0x00008000; load word 0x014 → 0x12340000.
- Handshake: hold Req with alternating addresses while Busy → only the first request is accepted; next accept occurs the cycle Ready rises; inputs changed mid-access do not alter the result.
- Boundary: load word index DEPTH (byte 0x400 with ADDR_WIDTH=11) → ReadData=0, Valid pulses. Reset asserted in WAIT during a store → no Valid; a later load of that address returns the old value.
- With DMEM_ALIGN_CHECK_EN: word load at 0x012 → Err=1 with Valid, ReadData=0. Half store at 0x013 → Err=1 and memory unchanged.
